fir_out_decim: RTL and testbench

Output conditioning stage placed directly downstream of the systolic FIR, on its `data_out`/`outdata_vld` pair. It keeps every DECIM-th valid filter sample, rounds and saturates it to the output word width, and buffers the result in a small FIFO with a valid/ready output handshake. The FIR has no backpressure, so the FIFO absorbs consumer stalls and reports sample loss through a sticky overflow flag.

---
 rtl/fir_pkg.sv | 58 +++++
 rtl/sync_fifo.sv | 97 +++++++++
 rtl/fir_out_decim.sv | 150 +++++++++++++++
 tb/tb_fir_out_decim.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR output conditioning stage.
//   - legal parameter ranges for fir_out_decim / sync_fifo
//   - SAT_W: internal working width of the rounding datapath. It is one bit
//     wider than the widest legal input, so the rounding add never overflows.
//   - sat_round(): round-half-up arithmetic shift followed by saturation to a
//     signed out_width-bit range. The result is returned sign-extended to SAT_W.
//   - is_pow2(): helper for the FIFO depth check
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int IN_WIDTH_MIN   = 1;
    localparam int IN_WIDTH_MAX   = 43;
    localparam int DECIM_MIN      = 1;
    localparam int DECIM_MAX      = 256;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int SAT_W          = IN_WIDTH_MAX + 1;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // x must already be sign-extended to SAT_W bits. shift and out_width are
    // elaboration constants at every call site, so this folds into a fixed
    // adder, a wire shift and two comparators.
    function automatic logic signed [SAT_W-1:0] sat_round(
        input logic signed [SAT_W-1:0] x,
        input int                      shift,
        input int                      out_width
    );
        logic signed [SAT_W-1:0] bias;
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] result;

        bias = '0;
        if (shift > 0) begin
            bias = SAT_W'(1) << (shift - 1);
        end
        sum     = x + bias;
        shifted = sum >>> shift;

        hi = (SAT_W'(1) << (out_width - 1)) - SAT_W'(1);
        lo = ~hi;   // two's complement: ~(2^(n-1)-1) == -2^(n-1)

        result = shifted;
        if (shifted > hi) begin
            result = hi;
        end else if (shifted < lo) begin
            result = lo;
        end
        return result;
    endfunction

endpackage : fir_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Show-ahead synchronous FIFO. The head entry is visible on rd_data whenever
// the FIFO is non-empty, and rd_data reads as zero while empty.
//
// Parameters
//   WIDTH  data width
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports
//   clk_main  in   clock
//   rst_n     in   asynchronous active-low reset (empties the FIFO)
//   clr       in   synchronous clear, overrides push/pop in the same cycle
//   push      in   write request. It is accepted when not full, or when full
//                  together with an accepted pop.
//   pop       in   read request. It is ignored while empty.
//   wr_data   in   data to write
//   rd_data   out  head entry
//   fill      out  occupancy 0..DEPTH
//   full      out  fill == DEPTH
//   empty     out  fill == 0
// -----------------------------------------------------------------------------
module sync_fifo
    import fir_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic                       clk_main,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     fill,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    if (!is_pow2(DEPTH) || DEPTH < FIFO_DEPTH_MIN) begin : g_bad_depth
        $fatal(1, "sync_fifo: DEPTH must be a power of two and at least 2");
    end

    // The read port is combinational because the show-ahead head must be
    // visible in the same cycle it is written into an empty FIFO.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   fill_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (fill_reg == '0);
    assign full    = (fill_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && (!full || do_pop) && !clr;

    // The pointers are exactly AW bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else if (clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill_reg <= fill_reg + (AW+1)'(1);
                2'b01:   fill_reg <= fill_reg - (AW+1)'(1);
                default: fill_reg <= fill_reg;
            endcase
        end
    end

    // The storage has no reset. An empty FIFO masks whatever the array holds.
    always_ff @(posedge clk_main) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr_reg];
    assign fill    = fill_reg;

endmodule : sync_fifo

// File: rtl/fir_out_decim.sv
// -----------------------------------------------------------------------------
// fir_out_decim
// Output conditioning stage behind the systolic FIR. It keeps every DECIM-th
// valid sample. Each kept sample is rounded (arithmetic right shift by SHIFT)
// and saturated to OUT_WIDTH bits, then buffered in a show-ahead FIFO with a
// valid/ready output. The FIR cannot be stalled, so a sample that meets a full
// FIFO without a simultaneous pop is dropped, and the sticky ovf flag is set.
//
// Ports
//   clk_main     in   clock
//   rst_n        in   asynchronous active-low reset
//   flush        in   sync clear of phase, stage register and FIFO (not ovf)
//   data_in      in   signed FIR sample, IN_WIDTH bits
//   indata_vld   in   data_in qualifier
//   data_out     out  signed FIFO head, OUT_WIDTH bits
//   outdata_vld  out  FIFO non-empty
//   out_rdy      in   consumer accepts data_out this cycle
//   fill         out  FIFO occupancy
//   ovf          out  sticky drop flag
//   ovf_clr      in   sync clear of ovf (a drop in the same cycle wins)
//
// Latency: a kept sample that arrives at edge k is in the stage register
// after edge k. It is pushed at edge k+1 and is visible on data_out after
// k+1 if the FIFO was empty.
// -----------------------------------------------------------------------------
module fir_out_decim
    import fir_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 12,
    parameter int SHIFT      = 4,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_main,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic signed [IN_WIDTH-1:0]    data_in,
    input  logic                          indata_vld,
    output logic signed [OUT_WIDTH-1:0]   data_out,
    output logic                          outdata_vld,
    input  logic                          out_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fill,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    if (IN_WIDTH < IN_WIDTH_MIN || IN_WIDTH > IN_WIDTH_MAX) begin : g_bad_in_width
        $fatal(1, "fir_out_decim: IN_WIDTH out of range 1..43");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > IN_WIDTH) begin : g_bad_out_width
        $fatal(1, "fir_out_decim: OUT_WIDTH out of range 1..IN_WIDTH");
    end
    if (SHIFT < 0 || SHIFT > IN_WIDTH - 1) begin : g_bad_shift
        $fatal(1, "fir_out_decim: SHIFT out of range 0..IN_WIDTH-1");
    end
    if (DECIM < DECIM_MIN || DECIM > DECIM_MAX) begin : g_bad_decim
        $fatal(1, "fir_out_decim: DECIM out of range 1..256");
    end
    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < FIFO_DEPTH_MIN) begin : g_bad_depth
        $fatal(1, "fir_out_decim: FIFO_DEPTH must be a power of two, >= 2");
    end

    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PH_W-1:0]             ph_reg;
    logic [PH_W-1:0]             ph_next;
    logic                        s_vld_reg;
    logic signed [OUT_WIDTH-1:0] s_data_reg;
    logic                        ovf_reg;
    logic                        ovf_next;

    logic signed [SAT_W-1:0]     din_ext;
    logic signed [OUT_WIDTH-1:0] rnd_sample;
    logic                        keep;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        pop_now;
    logic                        drop;

    // Sign-extend to the shared working width, then round and saturate.
    // The saturated value fits OUT_WIDTH, so truncation only removes sign copies.
    assign din_ext    = SAT_W'(data_in);
    assign rnd_sample = OUT_WIDTH'(sat_round(din_ext, SHIFT, OUT_WIDTH));

    assign keep = indata_vld && (ph_reg == '0);

    always_comb begin
        ph_next = ph_reg;
        if (indata_vld) begin
            ph_next = (ph_reg == PH_W'(DECIM - 1)) ? '0 : ph_reg + PH_W'(1);
        end
    end

    // A full FIFO still accepts the stage sample if the head leaves in the
    // same cycle, so only full-without-pop drops. Flush discards the stage
    // sample outright, so that case is not counted as a drop.
    assign pop_now = out_rdy && !fifo_empty;
    assign drop    = s_vld_reg && fifo_full && !pop_now && !flush;

    always_comb begin
        ovf_next = ovf_reg;
        if (drop) begin
            ovf_next = 1'b1;
        end else if (ovf_clr) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk_main or negedge rst_n) begin
        if (!rst_n) begin
            ph_reg     <= '0;
            s_vld_reg  <= 1'b0;
            s_data_reg <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
            if (flush) begin
                ph_reg    <= '0;
                s_vld_reg <= 1'b0;
            end else begin
                ph_reg    <= ph_next;
                s_vld_reg <= keep;
                if (keep) begin
                    s_data_reg <= rnd_sample;
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_main (clk_main),
        .rst_n    (rst_n),
        .clr      (flush),
        .push     (s_vld_reg),
        .pop      (out_rdy),
        .wr_data  (s_data_reg),
        .rd_data  (data_out),
        .fill     (fill),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign outdata_vld = !fifo_empty;
    assign ovf         = ovf_reg;

endmodule : fir_out_decim

// File: tb/tb_fir_out_decim.sv
// -----------------------------------------------------------------------------
// tb_fir_out_decim
// Self-checking bench for fir_out_decim (IN 16, OUT 12, SHIFT 4, DECIM 3,
// FIFO_DEPTH 8). A queue-based reference model predicts the output after
// every clock edge. The stimulus is directed scenarios followed by random
// traffic.
// -----------------------------------------------------------------------------
module tb_fir_out_decim;

    localparam int IN_W  = 16;
    localparam int OUT_W = 12;
    localparam int SH    = 4;
    localparam int DEC   = 3;
    localparam int DEPTH = 8;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic                     clk_main = 1'b0;
    logic                     rst_n;
    logic                     flush;
    logic signed [IN_W-1:0]   data_in;
    logic                     indata_vld;
    logic signed [OUT_W-1:0]  data_out;
    logic                     outdata_vld;
    logic                     out_rdy;
    logic [FW-1:0]            fill;
    logic                     ovf;
    logic                     ovf_clr;

    always #5 clk_main = ~clk_main;

    fir_out_decim #(
        .IN_WIDTH   (IN_W),
        .OUT_WIDTH  (OUT_W),
        .SHIFT      (SH),
        .DECIM      (DEC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_main    (clk_main),
        .rst_n       (rst_n),
        .flush       (flush),
        .data_in     (data_in),
        .indata_vld  (indata_vld),
        .data_out    (data_out),
        .outdata_vld (outdata_vld),
        .out_rdy     (out_rdy),
        .fill        (fill),
        .ovf         (ovf),
        .ovf_clr     (ovf_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the decimation count, the sample waiting to
    // enter the buffer, the buffer contents and the sticky flag.
    int m_ph;
    bit m_svld;
    int m_sdata;
    int m_q[$];
    bit m_ovf;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Round to nearest (ties up) after division by 2^SH, then clamp.
    function automatic int ref_sample(input int x);
        int r;
        int hi;
        int lo;
        hi = (1 << (OUT_W - 1)) - 1;
        lo = -(1 << (OUT_W - 1));
        r  = (x + (1 << (SH - 1))) >>> SH;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    task automatic model_reset();
        m_ph   = 0;
        m_svld = 0;
        m_sdata = 0;
        m_q.delete();
        m_ovf  = 0;
    endtask

    task automatic check_outputs();
        check_val("outdata_vld", int'(outdata_vld), (m_q.size() > 0) ? 1 : 0);
        check_val("fill", int'(fill), m_q.size());
        check_val("ovf", int'(ovf), int'(m_ovf));
        if (m_q.size() > 0) begin
            check_val("data_out", int'(data_out), m_q[0]);
        end
    endtask

    // One clock cycle: drive the inputs, advance the model across the edge,
    // then compare 1 time unit after the edge.
    task automatic step(input bit vld, input int d, input bit rdy, input bit fl, input bit oc);
        bit pop;
        bit push;
        data_in    = d[IN_W-1:0];
        indata_vld = vld;
        out_rdy    = rdy;
        flush      = fl;
        ovf_clr    = oc;
        @(posedge clk_main);
        if (fl) begin
            m_ph   = 0;
            m_svld = 0;
            m_q.delete();
            if (oc) m_ovf = 0;
        end else begin
            pop  = (m_q.size() > 0) && rdy;
            push = m_svld && ((m_q.size() < DEPTH) || pop);
            if (pop) begin
                $display("pop  sample=%0d occupancy_before=%0d", m_q[0], m_q.size());
                void'(m_q.pop_front());
            end
            if (push) m_q.push_back(m_sdata);
            if (m_svld && !push) m_ovf = 1;
            else if (oc)         m_ovf = 0;
            m_svld = vld && (m_ph == 0);
            if (m_svld) m_sdata = ref_sample(d);
            if (vld) m_ph = (m_ph + 1) % DEC;
        end
        #1;
        check_outputs();
    endtask

    // Pad with discarded samples until the next valid sample is the kept one.
    task automatic feed_kept(input int d, input bit rdy);
        while (m_ph != 0) step(1'b1, 0, rdy, 1'b0, 1'b0);
        step(1'b1, d, rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) step(1'b0, 0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        int         round_in[5];
        logic [15:0] r16;
        int         rdy_pct;

        rst_n = 1'b1; flush = 1'b0; data_in = '0; indata_vld = 1'b0;
        out_rdy = 1'b0; ovf_clr = 1'b0;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_vld", int'(outdata_vld), 0);
        check_val("rst_fill", int'(fill), 0);
        check_val("rst_ovf", int'(ovf), 0);
        check_val("rst_data", int'(data_out), 0);
        repeat (2) @(negedge clk_main);
        rst_n = 1'b1;

        // Decimation with consecutive valid inputs
        for (int i = 0; i < 12; i++) step(1'b1, i * 16, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);

        // Rounding and saturation corner values
        round_in = '{24, -24, 32767, -32768, 7};
        for (int i = 0; i < 5; i++) feed_kept(round_in[i], 1'b0);
        idle(1, 1'b0);
        check_val("sat_pos_head_seq", int'(fill), 5);
        idle(6, 1'b1);

        // Backpressure and overflow: ten kept samples into a stalled FIFO
        for (int i = 1; i <= 10; i++) feed_kept(i * 16, 1'b0);
        idle(1, 1'b0);
        check_val("bp_fill_full", int'(fill), DEPTH);
        check_val("bp_ovf_set", int'(ovf), 1);
        idle(10, 1'b1);

        // Full with simultaneous pop and push, then clear colliding with a drop
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) feed_kept(i * 16, 1'b0);
        idle(1, 1'b0);
        feed_kept(9 * 16, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        check_val("popush_fill", int'(fill), DEPTH);
        check_val("popush_ovf", int'(ovf), 0);
        feed_kept(10 * 16, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check_val("clr_vs_drop_ovf", int'(ovf), 1);
        idle(10, 1'b1);
        step(1'b0, 0, 1'b1, 1'b0, 1'b1);

        // Flush mid-stream with a sample in the flush cycle
        step(1'b1, 5 * 16, 1'b0, 1'b0, 1'b0);
        step(1'b1, 6 * 16, 1'b0, 1'b0, 1'b0);
        step(1'b1, 7 * 16, 1'b0, 1'b1, 1'b0);
        check_val("flush_fill", int'(fill), 0);
        for (int i = 0; i < 4; i++) step(1'b1, (100 + i) * 16, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_val("flush_head", int'(data_out), 100);
        idle(4, 1'b1);

        // Asynchronous reset between edges with five entries buffered
        for (int i = 1; i <= 5; i++) feed_kept(i * 160, 1'b0);
        idle(1, 1'b0);
        check_val("pre_rst_fill", int'(fill), 5);
        #3 rst_n = 1'b0;
        #1;
        check_val("arst_vld", int'(outdata_vld), 0);
        check_val("arst_fill", int'(fill), 0);
        check_val("arst_ovf", int'(ovf), 0);
        check_val("arst_data", int'(data_out), 0);
        model_reset();
        @(negedge clk_main);
        rst_n = 1'b1;
        step(1'b1, 320, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check_val("post_rst_first", int'(data_out), 20);
        idle(2, 1'b1);

        // Random traffic with varying consumer duty cycle
        for (int seg = 0; seg < 6; seg++) begin
            rdy_pct = (seg * 20) % 100 + 10;
            for (int c = 0; c < 300; c++) begin
                r16 = 16'($urandom);
                step($urandom_range(0, 3) != 0, int'($signed(r16)),
                     $urandom_range(0, 99) < rdy_pct,
                     $urandom_range(0, 63) == 0,
                     $urandom_range(0, 31) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fir_out_decim
